// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan driver: segment table,
// blank pattern and scan state encoding.
package seg7_pkg;

    // All segments off (active-low).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Hex digit to active-low {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // BLANK: dead time at slot start with all anodes off; ON: digit lit.
    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low segment decoder.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup into the shared segment constants.
    always_comb begin
        seg = SEG_TABLE[nibble];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a common-anode 7-segment display with
// per-slot blanking and frame-synchronous double-buffered data.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLANK_CYCLES = 2000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] DIGITS,
    input  logic [NUM_DIGITS-1:0]   DP_IN,
    input  logic [NUM_DIGITS-1:0]   DIGIT_EN,
    input  logic                    LOAD,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic [6:0]              SEG,
    output logic                    DP,
    output logic                    FRAME_DONE
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    scan_state_t      state;

    logic [4*NUM_DIGITS-1:0] pend_digits;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   pend_en;
    logic                    pend_valid;

    logic [4*NUM_DIGITS-1:0] act_digits;
    logic [NUM_DIGITS-1:0]   act_dp;
    logic [NUM_DIGITS-1:0]   act_en;

    logic                  slot_end;
    logic                  frame_end;
    logic [3:0]            cur_nibble;
    logic                  cur_dp;
    logic                  cur_en;
    logic [NUM_DIGITS-1:0] an_sel;
    logic [6:0]            dec_seg;

    assign slot_end  = (cnt == CNT_W'(SCAN_DIV - 1));
    assign frame_end = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));

    // Select the active digit; an out-of-range idx matches nothing, leaving it dark.
    always_comb begin
        cur_nibble = '0;
        cur_dp     = 1'b0;
        cur_en     = 1'b0;
        an_sel     = '1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nibble = act_digits[4*i +: 4];
                cur_dp     = act_dp[i];
                cur_en     = act_en[i];
                an_sel[i]  = 1'b0;
            end
        end
    end

    seg7_hex_decode u_decode (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    // Slot counter, digit index and blank/on state machine.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            idx   <= '0;
            state <= BLANK;
        end else begin
            if (slot_end) begin
                cnt   <= '0;
                state <= BLANK;
                if (idx == IDX_W'(NUM_DIGITS - 1)) begin
                    idx <= '0;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
                if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
                    state <= ON;
                end
            end
        end
    end

    // Pending/active buffers; a LOAD on the wrap edge bypasses pending straight to active.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_en     <= '0;
            pend_valid  <= 1'b0;
            act_digits  <= '0;
            act_dp      <= '0;
            act_en      <= '0;
        end else if (frame_end) begin
            pend_valid <= 1'b0;
            if (LOAD) begin
                pend_digits <= DIGITS;
                pend_dp     <= DP_IN;
                pend_en     <= DIGIT_EN;
                act_digits  <= DIGITS;
                act_dp      <= DP_IN;
                act_en      <= DIGIT_EN;
            end else if (pend_valid) begin
                act_digits <= pend_digits;
                act_dp     <= pend_dp;
                act_en     <= pend_en;
            end
        end else if (LOAD) begin
            pend_digits <= DIGITS;
            pend_dp     <= DP_IN;
            pend_en     <= DIGIT_EN;
            pend_valid  <= 1'b1;
        end
    end

    // Registered pin outputs, one cycle behind the scan position.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            AN         <= '1;
            SEG        <= SEG_BLANK;
            DP         <= 1'b1;
            FRAME_DONE <= 1'b0;
        end else begin
            FRAME_DONE <= frame_end;
            if ((state == ON) && cur_en) begin
                AN  <= an_sel;
                SEG <= dec_seg;
                DP  <= ~cur_dp;
            end else begin
                AN  <= '1;
                SEG <= SEG_BLANK;
                DP  <= 1'b1;
            end
        end
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Output-side counterpart of the button input conditioning: it drives the board's 8-digit common-anode 7-segment display from a clean parallel value.
- Time-multiplexes the digits with a fixed refresh slot per digit and a blanking dead time between digits, which suppresses ghosting.
- Parallel data is double-buffered and only takes effect at frame boundaries, so a displayed frame never tears.
- Sits between the application logic (counters, debounced button handlers) and the AN/SEG/DP pins.

Parameters:
- NUM_DIGITS, 8: number of multiplexed digits. Legal range is 2..8.
- SCAN_DIV, 100000: clock cycles per digit slot, which gives 1 ms per slot at 100 MHz.
- BLANK_CYCLES, 2000: cycles at the start of each slot with all anodes off. Must satisfy 1 <= BLANK_CYCLES < SCAN_DIV.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- DIGITS  in  4*NUM_DIGITS  hex nibble per digit; digit 0 is in bits [3:0].
- DP_IN  in  NUM_DIGITS  decimal point enable per digit, active-high.
- DIGIT_EN  in  NUM_DIGITS  per-digit enable; 0 blanks that digit.
- LOAD  in  1  one-cycle strobe that captures DIGITS, DP_IN and DIGIT_EN into the pending buffer.
- AN  out  NUM_DIGITS  anode selects, active-low.
- SEG  out  7  segments {g,f,e,d,c,b,a}, active-low.
- DP  out  1  decimal point, active-low.
- FRAME_DONE  out  1  one-cycle pulse at each frame wrap.

Behaviour:
- Reset (rst_n low at a clk edge):
  - Outputs: AN all 1, SEG 7'h7F, DP 1, FRAME_DONE 0.
  - Internal: slot counter 0, digit index 0, pending-valid flag 0, pending and active buffers cleared to all zeros. A cleared active buffer has DIGIT_EN=0, so the display is dark until the first LOAD takes effect.
  - Reset mid-frame aborts the frame immediately. A pending LOAD is discarded.
- Slot counter:
  - cnt runs 0..SCAN_DIV-1, then wraps to 0.
  - On wrap, idx increments. From NUM_DIGITS-1, idx wraps to 0, which marks a frame wrap.
- State machine (two states, a function of cnt):
  - BLANK for cnt in [0, BLANK_CYCLES-1].
  - ON for cnt in [BLANK_CYCLES, SCAN_DIV-1].
  - ON returns to BLANK on slot wrap.
- Outputs are registered with one clock of latency from (cnt, idx, state):
  - BLANK: AN all 1, SEG 7'h7F, DP 1.
  - ON with active DIGIT_EN[idx]=1: AN[idx]=0 and all other anodes 1; SEG is the decoded active nibble idx; DP = ~active DP_IN[idx].
  - ON with DIGIT_EN[idx]=0: AN stays all 1, SEG 7'h7F, DP 1. The slot length is unchanged, so brightness stays uniform across digits.
  - SEG and DP change only while AN is all 1. Segment data never changes while an anode is on.
- Buffering:
  - LOAD high at an edge captures the inputs into the pending buffer and sets the pending-valid flag.
  - Several LOADs before a wrap: the last one wins.
  - At frame wrap (cnt==SCAN_DIV-1 and idx==NUM_DIGITS-1), if pending-valid is set, pending is copied to active and the flag is cleared.
  - LOAD in the same cycle as the frame wrap: the inputs go directly to active at that wrap and the flag ends up cleared.
- FRAME_DONE: high for exactly the one cycle after the frame-wrap edge.
- Decode, hex to active-low {g..a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Width rules:
  - cnt width is clog2(SCAN_DIV); idx width is clog2(NUM_DIGITS).
  - No state is reachable outside the legal ranges. Out-of-range idx (for non-power-of-2 NUM_DIGITS) is unreachable, and AN is all 1 if forced there.

Decomposition:
- Shared package seg7_pkg:
  - 16-entry active-low segment constant table.
  - SEG_BLANK = 7'h7F.
  - Scan state enum {BLANK, ON}.
- One sub-module, seg7_hex_decode: 4-bit nibble in, 7-bit active-low segments out, purely combinational.
- The top level holds the counter, FSM, buffers and output registers.

Test Plan (SCAN_DIV=8, BLANK_CYCLES=2, NUM_DIGITS=8):
1. Reset, then release rst_n with no LOAD -> AN=FF, SEG=7F, DP=1 for the whole first frame of 64 cycles; FRAME_DONE pulses once at cycle 64.
2. LOAD DIGITS=32'h89ABCDEF, DP_IN=8'h01, DIGIT_EN=8'hFF, then wait for the wrap -> in the next frame, digit 0 shows SEG=0E, DP=0, AN=FE for cycles 2..7 of its slot. Digit 7 shows SEG=00, AN=7F, DP=1. Each slot has exactly 2 blank cycles with AN=FF.
3. Blanking check: with DIGIT_EN=8'hFF, AN must never have two bits low at once, and must be FF on every cycle where SEG changes. Checked by assertion over 3 frames.
4. DIGIT_EN=8'b1010_1010 -> the anodes of digits 0, 2, 4 and 6 stay high for their whole slot. FRAME_DONE period stays 64 cycles.
5. Two LOADs mid-frame (values 0x11111111 then 0x22222222), plus a third LOAD (0x33333333) coincident with the frame wrap -> the display never shows 1 or 2; it shows 3 from the next frame. The pending flag is clear afterwards.
6. Assert rst_n low at cycle 30 of a displaying frame -> at the next edge AN=FF and SEG=7F. After release the display stays dark, because the active buffer was cleared and the pending LOAD was dropped.
